// File: rtl/project_mux_ctrl.sv
// Wishbone-controlled pad mux that connects one of NUM_PROJECTS user designs to the shared IO pads.
// A project switch isolates the pads for a drain period, then holds the incoming project in reset before connecting it.
module project_mux_ctrl #(
   parameter int          NUM_PROJECTS    = 8,
   parameter int          IO_PADS         = 38,
   parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
   parameter int          DEFAULT_PROJECT = 0,
   parameter int          SETTLE_CYCLES   = 4,
   parameter int          RST_CYCLES      = 8,
   parameter bit          HOLD_INACTIVE   = 1'b1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wbs_stb_i,
   input  logic                            wbs_cyc_i,
   input  logic                            wbs_we_i,
   input  logic [3:0]                      wbs_sel_i,
   input  logic [31:0]                     wbs_adr_i,
   input  logic [31:0]                     wbs_dat_i,
   output logic                            wbs_ack_o,
   output logic [31:0]                     wbs_dat_o,
   input  logic [IO_PADS-1:0]              io_in,
   output logic [IO_PADS-1:0]              io_out,
   output logic [IO_PADS-1:0]              io_oeb,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
   input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_oeb,
   output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
   output logic [NUM_PROJECTS-1:0]         proj_rst,
   output logic [7:0]                      active_o,
   output logic [1:0]                      o_dbg_state
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_DRAIN    = 2'd1;
   localparam logic [1:0] ST_RST_HOLD = 2'd2;

   localparam int CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SR_W    = (NUM_PROJECTS < 32) ? NUM_PROJECTS : 32;

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [7:0]       DEFAULT_IDX = 8'(DEFAULT_PROJECT);
   localparam logic [8:0]       NP_LIMIT    = 9'(NUM_PROJECTS);

   logic [1:0]              r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [7:0]              r_current;
   logic [7:0]              r_pending;
   logic                    r_bringup;
   logic [NUM_PROJECTS-1:0] r_soft_rst;
   logic [15:0]             r_switch_cnt;
   logic                    r_err_inv;
   logic                    r_err_busy;
   logic                    r_ack;
   logic [31:0]             r_dat;

   logic        w_in_win;
   logic [31:0] w_rel;
   logic [1:0]  w_off;
   logic        w_req;
   logic        w_wr;
   logic        w_rd;
   logic        w_act_wr;
   logic [7:0]  w_new;
   logic [31:0] w_rdata;
   logic [31:0] w_soft_rd;
   logic        w_unused;

   // r_ack in the request term keeps ack from firing on back-to-back cycles
   assign w_in_win = (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i <= (BASE_ADDR + 32'd15));
   assign w_rel    = wbs_adr_i - BASE_ADDR;
   assign w_off    = w_rel[3:2];
   assign w_req    = wbs_cyc_i & wbs_stb_i & w_in_win & ~r_ack;
   assign w_wr     = w_req & wbs_we_i;
   assign w_rd     = w_req & ~wbs_we_i;
   assign w_act_wr = w_wr && (w_off == 2'd0) && wbs_sel_i[0];
   assign w_new    = wbs_dat_i[7:0];
   assign w_unused = ^{wbs_dat_i, wbs_sel_i, w_rel};

   assign w_soft_rd = 32'(r_soft_rst[SR_W-1:0]);

   always_comb begin
      w_rdata = '0;
      case (w_off)
         2'd0: w_rdata = {24'h0, r_current};
         2'd1: w_rdata = {16'h0, r_current, 5'h0, r_err_busy, r_err_inv, (r_state != ST_RUN)};
         2'd2: w_rdata = w_soft_rd;
         2'd3: w_rdata = {16'h0, r_switch_cnt};
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_RST_HOLD;
         r_cnt        <= RST_LOAD;
         r_current    <= DEFAULT_IDX;
         r_pending    <= DEFAULT_IDX;
         r_bringup    <= 1'b1;
         r_soft_rst   <= '0;
         r_switch_cnt <= '0;
         r_err_inv    <= 1'b0;
         r_err_busy   <= 1'b0;
         r_ack        <= 1'b0;
         r_dat        <= '0;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rd ? w_rdata : 32'h0;

         if (w_wr && (w_off == 2'd1)) begin
            r_err_inv  <= 1'b0;
            r_err_busy <= 1'b0;
         end

         if (w_wr && (w_off == 2'd2)) begin
            for (int i = 0; i < SR_W; i++) begin
               if (wbs_sel_i[i/8]) r_soft_rst[i] <= wbs_dat_i[i];
            end
         end

         if (w_act_wr && (r_state != ST_RUN)) r_err_busy <= 1'b1;

         case (r_state)
            ST_RUN: begin
               if (w_act_wr && (w_new != r_current)) begin
                  if ({1'b0, w_new} >= NP_LIMIT) begin
                     r_err_inv <= 1'b1;
                  end else begin
                     r_pending <= w_new;
                     r_cnt     <= SETTLE_LOAD;
                     r_state   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_cnt == '0) begin
                  r_current <= r_pending;
                  r_cnt     <= RST_LOAD;
                  r_state   <= ST_RST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RST_HOLD: begin
               // the post-reset bring-up pass leaves the switch counter alone
               if (r_cnt == '0) begin
                  r_state   <= ST_RUN;
                  r_bringup <= 1'b0;
                  if (!r_bringup && (r_switch_cnt != 16'hFFFF)) r_switch_cnt <= r_switch_cnt + 16'd1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_RST_HOLD;
               r_cnt   <= RST_LOAD;
            end
         endcase
      end
   end

   always_comb begin
      io_out     = '0;
      io_oeb     = '1;
      proj_io_in = '0;
      for (int i = 0; i < NUM_PROJECTS; i++) begin
         if ((r_state == ST_RUN) && (r_current == 8'(i))) begin
            io_out                          = proj_io_out[i*IO_PADS +: IO_PADS];
            io_oeb                          = proj_io_oeb[i*IO_PADS +: IO_PADS];
            proj_io_in[i*IO_PADS +: IO_PADS] = io_in;
         end
      end
   end

   always_comb begin
      proj_rst = '0;
      for (int i = 0; i < NUM_PROJECTS; i++) begin
         proj_rst[i] = reset | r_soft_rst[i]
                     | ((r_state == ST_RST_HOLD) && (r_current == 8'(i)))
                     | (HOLD_INACTIVE && (r_current != 8'(i)));
      end
   end

   assign wbs_ack_o   = r_ack;
   assign wbs_dat_o   = r_dat;
   assign active_o    = r_current;
   assign o_dbg_state = r_state;

endmodule

// File: doc/project_mux_ctrl.md
Name: project_mux_ctrl

Overview:
Parametrised successor to the fixed five-way user-project harness mux. It selects one of NUM_PROJECTS designs onto the shared IO pads under Wishbone control. Project switching is glitch-safe: the pads are isolated for a drain period, then the incoming project is held in reset before it is connected. The block also adds per-project output-enable passthrough, soft-reset control, a status register and a switch counter. It sits between the Caravel user-area Wishbone/IO ports and the project instances.

Parameters:
NUM_PROJECTS, 8, number of selectable projects (2..256)
IO_PADS, 38, pad count per project bus
BASE_ADDR, 32'h30000000, base of the 16-byte register window
DEFAULT_PROJECT, 0, project selected after reset
SETTLE_CYCLES, 4, drain cycles with pads isolated (>=1)
RST_CYCLES, 8, reset-hold cycles for the incoming project (>=1)
HOLD_INACTIVE, 1, if 1 all non-selected projects are held in reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  IO_PADS  pad inputs
io_out  out  IO_PADS  pad outputs
io_oeb  out  IO_PADS  pad output-enable, active low
proj_io_out  in  NUM_PROJECTS*IO_PADS  flattened project outputs; slice i = [i*IO_PADS +: IO_PADS]
proj_io_oeb  in  NUM_PROJECTS*IO_PADS  flattened project oeb
proj_io_in  out  NUM_PROJECTS*IO_PADS  gated pad inputs per project
proj_rst  out  NUM_PROJECTS  per-project reset, active high
active_o  out  8  currently connected project index

Behaviour:
- Registers (offsets from BASE_ADDR):
  - 0x0 ACTIVE: rw, bits[7:0]; a write takes effect only when sel[0]=1.
  - 0x4 STATUS: ro. bit0 = switching (state != RUN); bit1 = sticky invalid-index error; bit2 = sticky busy error; bits[15:8] = current index.
  - 0x8 SOFT_RST: rw, bits[NUM_PROJECTS-1:0]; each byte lane is written only when its sel bit is 1.
  - 0xC SWITCH_CNT: ro, 16-bit count of completed switches; saturates at 16'hFFFF.
  - Any write to STATUS clears bits 1 and 2.
- Wishbone handshake:
  - A request is valid when cyc&stb and the address lies in [BASE_ADDR, BASE_ADDR+15].
  - ack pulses for exactly one cycle, registered, one cycle after a valid request; it is never asserted on consecutive cycles.
  - Unmapped word offsets inside the window: ack, read 0, writes ignored. Addresses outside the window: no ack. Read data is valid in the ack cycle and 0 otherwise.
- FSM states: RUN, DRAIN, RST_HOLD; a single down-counter of width clog2(max(SETTLE_CYCLES,RST_CYCLES)+1).
  - RUN, ACTIVE write with value == current: ack only; no switch, no count.
  - RUN, ACTIVE write with value >= NUM_PROJECTS: ack, ignore, set STATUS.bit1.
  - RUN, valid new value: pending <= value; go to DRAIN with counter = SETTLE_CYCLES-1.
  - DRAIN: decrement the counter. At 0: current <= pending, counter = RST_CYCLES-1, go to RST_HOLD.
  - RST_HOLD: decrement the counter. At 0: go to RUN and increment SWITCH_CNT.
  - Any ACTIVE write while not in RUN: ack, ignore, set STATUS.bit2.
- Datapath (combinational from registered state):
  - In RUN: io_out = slice[current] of proj_io_out; io_oeb = slice[current] of proj_io_oeb; proj_io_in slice[current] = io_in; all other slices = 0.
  - In DRAIN or RST_HOLD: io_out = 0, io_oeb = all 1s, all proj_io_in slices = 0.
- proj_rst[i] = reset | SOFT_RST[i] | (state==RST_HOLD && i==current) | (HOLD_INACTIVE && i!=current).
- Reset (registered values):
  - current = DEFAULT_PROJECT; state = RST_HOLD with counter = RST_CYCLES-1; SOFT_RST = 0; SWITCH_CNT = 0; status sticky bits = 0; ack = 0; read data = 0.
  - Consequences: io_out = 0, io_oeb = all 1s, all proj_rst = 1 while reset is high. The default project connects after RST_CYCLES further cycles. This bring-up pass does not count as a switch.
- Reset asserted mid-switch: the FSM abandons the switch, pending is discarded, and the block returns to the reset state above.

Test Plan:
- Reset released, RST_CYCLES=8: proj_rst[0] stays high for exactly 8 cycles, then io_out == proj_io_out slice 0, STATUS=0x0000, SWITCH_CNT=0.
- Write ACTIVE=3, sel=4'b0001: ack one cycle later. io_out=0 and io_oeb=all 1s for 4+8 cycles; proj_rst[3] high for the last 8 of them; then io_out = slice 3, active_o=3, SWITCH_CNT=1, proj_io_in slice 3 == io_in and all other slices 0.
- Write ACTIVE=9 with NUM_PROJECTS=8: acked, active_o unchanged, STATUS bit1=1. Write STATUS: bit1 cleared.
- Write ACTIVE=5 and then, during DRAIN, ACTIVE=2: switch completes to 5, STATUS bit2=1, SWITCH_CNT increments by 1 only.
- Write SOFT_RST=0x04 while project 2 is active: proj_rst[2]=1 and the pads stay connected. Read at 0x8 returns 0x04; read at 0x10 (outside window) gets no ack; read at 0x0C returns SWITCH_CNT.
- Assert reset during RST_HOLD of a switch to 6: after release, active_o=DEFAULT_PROJECT, SWITCH_CNT=0, project 6 held in reset (HOLD_INACTIVE=1).
